// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Plays a song stored in an on-chip note table. Each entry holds a tone index
// and a 3-bit duration code. Entries are played in order. After each note a
// fixed silent gap is inserted. An entry with duration code 0 marks the end of
// the song.
//
// Ports
//   i_sys_clk    single clock; all logic on the rising edge
//   i_sys_rst    synchronous, active-high reset
//   i_tick_1ms   one-cycle timebase strobe
//   i_wr_en      note-table write strobe
//   i_wr_addr    note-table write address
//   i_wr_data    table entry {tone, dur_code[2:0]}
//   i_cmd_valid  command strobe
//   i_cmd        00 stop, 01 play, 10 pause/resume toggle, 11 ignored
//   i_loop_en    restart from entry 0 at end of song
//   o_note_out   current tone index, 0 = silence
//   o_tone_en    high while a note is sounding
//   o_busy       high in any state except IDLE
//   o_cur_addr   index of the entry being played
//   o_done       one-cycle pulse when the song ends without looping
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int DEPTH  = 128,
  parameter int NOTE_W = 5,
  parameter int DUR1   = 200,
  parameter int DUR2   = 500,
  parameter int DUR3   = 1000,
  parameter int DUR4   = 2000,
  parameter int DUR5   = 4000,
  parameter int GAP_T  = 10
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  input  logic                     i_tick_1ms,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [NOTE_W+2:0]        i_wr_data,
  input  logic                     i_cmd_valid,
  input  logic [1:0]               i_cmd,
  input  logic                     i_loop_en,
  output logic [NOTE_W-1:0]        o_note_out,
  output logic                     o_tone_en,
  output logic                     o_busy,
  output logic [$clog2(DEPTH)-1:0] o_cur_addr,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [15:0]   L_DUR1     = 16'(DUR1);
  localparam logic [15:0]   L_DUR2     = 16'(DUR2);
  localparam logic [15:0]   L_DUR3     = 16'(DUR3);
  localparam logic [15:0]   L_DUR4     = 16'(DUR4);
  localparam logic [15:0]   L_DUR5     = 16'(DUR5);
  localparam logic [15:0]   L_GAP_LAST = (GAP_T > 0) ? 16'(GAP_T - 1) : 16'd0;
  localparam logic [AW-1:0] L_LAST     = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_PAUSE
  } state_t;

  // Note table. The read port is registered and samples the old word when a
  // write hits the same address in the same cycle.
  logic [NOTE_W+2:0] r_mem [DEPTH];
  logic [NOTE_W+2:0] r_rd_data;

  // NOTE: the table is deliberately left out of reset; RAM macros have no reset
  // and the song must survive a reset pulse.
  always_ff @(posedge i_sys_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[o_cur_addr];
  end

  logic [NOTE_W-1:0] w_rd_tone;
  logic [2:0]        w_rd_code;
  assign w_rd_tone = r_rd_data[NOTE_W+2:3];
  assign w_rd_code = r_rd_data[2:0];

  // Control registers and their next values.
  state_t            r_state,    w_state_nxt;
  state_t            r_resume,   w_resume_nxt;
  logic [AW-1:0]     r_cur_addr, w_addr_nxt;
  logic [15:0]       r_cnt,      w_cnt_nxt;
  logic [15:0]       r_dur,      w_dur_nxt;
  logic [NOTE_W-1:0] r_tone,     w_tone_nxt;
  logic              r_done,     w_done_nxt;

  logic w_cmd_stop, w_cmd_play, w_cmd_pause, w_tick;
  logic w_next_entry, w_end_song;
  logic [15:0] w_dur_sel;

  assign w_cmd_stop  = i_cmd_valid && (i_cmd == 2'b00);
  assign w_cmd_play  = i_cmd_valid && (i_cmd == 2'b01);
  assign w_cmd_pause = i_cmd_valid && (i_cmd == 2'b10);
  // A command in the same cycle as a tick swallows the tick.
  assign w_tick = i_tick_1ms && !(w_cmd_stop || w_cmd_play || w_cmd_pause);

  // Duration lookup; codes 6 and 7 fall back to the shortest note.
  always_comb begin
    case (w_rd_code)
      3'd2:    w_dur_sel = L_DUR2;
      3'd3:    w_dur_sel = L_DUR3;
      3'd4:    w_dur_sel = L_DUR4;
      3'd5:    w_dur_sel = L_DUR5;
      default: w_dur_sel = L_DUR1;
    endcase
  end

  // State register.
  // NOTE: clocked state is written with <= so every register samples values
  // from before the edge, independent of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state    <= S_IDLE;
      r_resume   <= S_PLAY;
      r_cur_addr <= '0;
      r_cnt      <= '0;
      r_dur      <= '0;
      r_tone     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_resume   <= w_resume_nxt;
      r_cur_addr <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dur      <= w_dur_nxt;
      r_tone     <= w_tone_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_addr_nxt   = r_cur_addr;
    w_cnt_nxt    = r_cnt;
    w_dur_nxt    = r_dur;
    w_tone_nxt   = r_tone;
    w_done_nxt   = 1'b0;
    w_next_entry = 1'b0;
    w_end_song   = 1'b0;

    if (w_cmd_stop) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_tone_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_play) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end
        end
        S_FETCH: w_state_nxt = S_LOAD;
        S_LOAD: begin
          if (w_rd_code == 3'd0) begin
            w_end_song = 1'b1;
          end else begin
            w_tone_nxt  = w_rd_tone;
            w_dur_nxt   = w_dur_sel;
            w_cnt_nxt   = '0;
            w_state_nxt = S_PLAY;
          end
        end
        S_PLAY: begin
          if (w_cmd_pause) begin
            w_state_nxt  = S_PAUSE;
            w_resume_nxt = S_PLAY;
          end else if (w_tick) begin
            if (r_cnt == r_dur - 16'd1) begin
              w_cnt_nxt = '0;
              if (GAP_T == 0) w_next_entry = 1'b1;
              else            w_state_nxt  = S_GAP;
            end else begin
              w_cnt_nxt = r_cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (w_cmd_pause) begin
            w_state_nxt  = S_PAUSE;
            w_resume_nxt = S_GAP;
          end else if (w_tick) begin
            if (r_cnt == L_GAP_LAST) w_next_entry = 1'b1;
            else                     w_cnt_nxt    = r_cnt + 16'd1;
          end
        end
        S_PAUSE: begin
          if (w_cmd_pause) w_state_nxt = r_resume;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_next_entry) begin
      if (r_cur_addr != L_LAST) begin
        w_addr_nxt  = r_cur_addr + 1'b1;
        w_state_nxt = S_FETCH;
      end else begin
        w_end_song = 1'b1;
      end
    end

    // An end marker at entry 0 would loop forever, so it always finishes.
    if (w_end_song) begin
      w_addr_nxt = '0;
      w_cnt_nxt  = '0;
      if (i_loop_en && (r_cur_addr != '0)) begin
        w_state_nxt = S_FETCH;
      end else begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Outputs. The tone is only driven in PLAY, which silences PAUSE and GAP
  // while the saved tone is kept for resume.
  always_comb begin
    o_note_out = (r_state == S_PLAY) ? r_tone : '0;
    o_tone_en  = (r_state == S_PLAY) && (r_tone != '0);
    o_busy     = (r_state != S_IDLE);
    o_cur_addr = r_cur_addr;
    o_done     = r_done;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed scenarios for note_sequencer with DEPTH=4 and default durations.
// The driver pushes the expected output tuple and the cycle it must appear on.
// The monitor pops one entry whenever the output tuple changes and compares the
// tuple and its cycle against that entry.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int NW = 5;
  localparam int AW = 2;
  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_PLAY  = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       = 1'b1;
  logic          tick      = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [NW+2:0] wr_data   = '0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd       = 2'b00;
  logic          loop_en   = 1'b0;
  logic [NW-1:0] note_out;
  logic          tone_en, busy, done;
  logic [AW-1:0] cur_addr;

  note_sequencer #(.DEPTH(4), .NOTE_W(NW), .GAP_T(10)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_tick_1ms  (tick),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_cmd_valid (cmd_valid),
    .i_cmd       (cmd),
    .i_loop_en   (loop_en),
    .o_note_out  (note_out),
    .o_tone_en   (tone_en),
    .o_busy      (busy),
    .o_cur_addr  (cur_addr),
    .o_done      (done)
  );

  typedef struct {
    int         cyc;
    logic [9:0] val;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [9:0] prev   = '0;
  logic [9:0] w_act;

  assign w_act = {note_out, tone_en, busy, cur_addr, done};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every change of the output tuple consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en && (w_act !== prev)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change at cycle %0d: got 0x%0h expected no change", cyc, w_act);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_cycle"}, cyc, mon_e.cyc);
        check({mon_e.tag, "_value"}, 32'(w_act), 32'(mon_e.val));
      end
    end
    prev <= w_act;
  end

  function automatic logic [9:0] tup(input logic [NW-1:0] n, input logic en, input logic b,
                                     input logic [AW-1:0] a, input logic d);
    return {n, en, b, a, d};
  endfunction

  function automatic logic [NW+2:0] ent(input logic [NW-1:0] t, input logic [2:0] c);
    return {t, c};
  endfunction

  task automatic want(input int e, input logic [9:0] v, input string tag);
    exp_t x;
    x.cyc = e;
    x.val = v;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // Return just after edge e-1, so inputs set now are sampled at edge e.
  task automatic go_to(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int e, input logic [1:0] c);
    go_to(e);
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NW+2:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  int p, q, f;
  logic [9:0] idle_t;

  initial begin
    idle_t = tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", 32'(w_act), 32'(idle_t));
    mon_en = 1'b1;
    tick   = 1'b1;

    // A: two notes then end marker; play coincident with a tick; play while busy.
    wr(2'd0, ent(5'd5, 3'd1));
    wr(2'd1, ent(5'd7, 3'd2));
    wr(2'd2, ent(5'd0, 3'd0));
    wr(2'd3, ent(5'd0, 3'd0));
    p = cyc + 2;
    want(p,       tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "A_fetch0");
    want(p + 2,   tup(5'd5, 1'b1, 1'b1, 2'd0, 1'b0), "A_note5");
    want(p + 202, tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "A_gap0");
    want(p + 212, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "A_fetch1");
    want(p + 214, tup(5'd7, 1'b1, 1'b1, 2'd1, 1'b0), "A_note7");
    want(p + 714, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "A_gap1");
    want(p + 724, tup(5'd0, 1'b0, 1'b1, 2'd2, 1'b0), "A_fetch2");
    want(p + 726, tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b1), "A_done");
    want(p + 727, idle_t,                            "A_idle");
    send(p, C_PLAY);
    send(p + 213, C_PLAY);
    go_to(p + 740);

    // B: looping through the last entry, then loop disabled mid-pass.
    for (int k = 0; k < 4; k++) wr(AW'(k), ent(5'd3, 3'd1));
    loop_en = 1'b1;
    p = cyc + 2;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        f = p + (pass * 4 + k) * 212;
        want(f,       tup(5'd0, 1'b0, 1'b1, AW'(k), 1'b0), $sformatf("B_p%0d_e%0d_fetch", pass, k));
        want(f + 2,   tup(5'd3, 1'b1, 1'b1, AW'(k), 1'b0), $sformatf("B_p%0d_e%0d_note", pass, k));
        want(f + 202, tup(5'd0, 1'b0, 1'b1, AW'(k), 1'b0), $sformatf("B_p%0d_e%0d_gap", pass, k));
      end
    end
    want(p + 1696, tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b1), "B_done");
    want(p + 1697, idle_t,                            "B_idle");
    send(p, C_PLAY);
    go_to(p + 1000);
    loop_en = 1'b0;
    go_to(p + 1710);

    // C: pause after 50 ticks, 1000 idle ticks, resume; 150 ticks remain.
    wr(2'd0, ent(5'd5, 3'd1));
    wr(2'd1, ent(5'd0, 3'd0));
    p = cyc + 2;
    want(p,        tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "C_fetch0");
    want(p + 2,    tup(5'd5, 1'b1, 1'b1, 2'd0, 1'b0), "C_note5");
    want(p + 53,   tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "C_paused");
    want(p + 1053, tup(5'd5, 1'b1, 1'b1, 2'd0, 1'b0), "C_resumed");
    want(p + 1203, tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "C_gap0");
    want(p + 1213, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "C_fetch1");
    want(p + 1215, tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b1), "C_done");
    want(p + 1216, idle_t,                            "C_idle");
    send(p, C_PLAY);
    send(p + 53, C_PAUSE);
    send(p + 1053, C_PAUSE);
    go_to(p + 1230);

    // D: stop during the gap after entry 1; no done pulse.
    wr(2'd0, ent(5'd5, 3'd1));
    wr(2'd1, ent(5'd7, 3'd2));
    wr(2'd2, ent(5'd0, 3'd0));
    p = cyc + 2;
    want(p,       tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "D_fetch0");
    want(p + 2,   tup(5'd5, 1'b1, 1'b1, 2'd0, 1'b0), "D_note5");
    want(p + 202, tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "D_gap0");
    want(p + 212, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "D_fetch1");
    want(p + 214, tup(5'd7, 1'b1, 1'b1, 2'd1, 1'b0), "D_note7");
    want(p + 714, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "D_gap1");
    want(p + 717, idle_t,                            "D_stop");
    send(p, C_PLAY);
    send(p + 717, C_STOP);
    go_to(p + 740);

    // E: end marker at entry 0 with loop enabled never loops.
    wr(2'd0, ent(5'd0, 3'd0));
    loop_en = 1'b1;
    p = cyc + 2;
    want(p,     tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "E_fetch0");
    want(p + 2, tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b1), "E_done");
    want(p + 3, idle_t,                            "E_idle");
    send(p, C_PLAY);
    go_to(p + 20);
    loop_en = 1'b0;

    // F: reset pulse mid-note, then the table still plays the same note.
    wr(2'd0, ent(5'd9, 3'd3));
    wr(2'd1, ent(5'd0, 3'd0));
    p = cyc + 2;
    want(p,      tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "F_fetch0");
    want(p + 2,  tup(5'd9, 1'b1, 1'b1, 2'd0, 1'b0), "F_note9");
    want(p + 50, idle_t,                            "F_reset");
    send(p, C_PLAY);
    go_to(p + 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q = cyc + 2;
    want(q,      tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "F_refetch0");
    want(q + 2,  tup(5'd9, 1'b1, 1'b1, 2'd0, 1'b0), "F_readback");
    want(q + 10, idle_t,                            "F_stop");
    send(q, C_PLAY);
    send(q + 10, C_STOP);
    go_to(q + 20);

    // G: rest entry (tone 0), code 7 acting as code 1, entry rewritten during play.
    wr(2'd0, ent(5'd0, 3'd1));
    wr(2'd1, ent(5'd2, 3'd2));
    wr(2'd2, ent(5'd0, 3'd0));
    p = cyc + 2;
    want(p,       tup(5'd0, 1'b0, 1'b1, 2'd0, 1'b0), "G_fetch0");
    want(p + 212, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "G_fetch1");
    want(p + 214, tup(5'd4, 1'b1, 1'b1, 2'd1, 1'b0), "G_note4");
    want(p + 414, tup(5'd0, 1'b0, 1'b1, 2'd1, 1'b0), "G_gap1");
    want(p + 424, tup(5'd0, 1'b0, 1'b1, 2'd2, 1'b0), "G_fetch2");
    want(p + 426, tup(5'd0, 1'b0, 1'b0, 2'd0, 1'b1), "G_done");
    want(p + 427, idle_t,                            "G_idle");
    send(p, C_PLAY);
    go_to(p + 100);
    wr(2'd1, ent(5'd4, 3'd7));
    go_to(p + 440);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
